text_buffer_writer: RTL

- Writer side of the character-cell text path. Accepts ASCII bytes over a valid/ready handshake and keeps a cursor.
- Issues single-cycle writes into the character RAM that the text renderer reads, addressed by {row, column}, which matches the renderer's char_xy fields.
- Sits between a byte source (UART receiver, keyboard decoder, game logic) and the dual-port char RAM.

---
 rtl/text_buffer_writer_if.sv | 25 ++
 rtl/text_buffer_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer_if.sv
// Byte-source and char-RAM write bus for the text buffer writer.
// The master modport is the byte source / RAM side; the slave modport is the writer.
interface text_buffer_writer_if;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       clear;
   logic       wr_en;
   logic [7:0] wr_x;
   logic [7:0] wr_y;
   logic [7:0] wr_data;
   logic [7:0] cursor_x;
   logic [7:0] cursor_y;
   logic       busy;

   modport master (
      output char_in, char_valid, clear,
      input  char_ready, wr_en, wr_x, wr_y, wr_data, cursor_x, cursor_y, busy
   );

   modport slave (
      input  char_in, char_valid, clear,
      output char_ready, wr_en, wr_x, wr_y, wr_data, cursor_x, cursor_y, busy
   );
endinterface

// File: rtl/text_buffer_writer.sv
// Cursor-based writer into the character RAM: clears on reset/clear, then places bytes.
// Define TEXT_WRITER_LINE_CLEAR_EN to blank each new row on every row advance.
module text_buffer_writer #(
   parameter int         COLS  = 16,
   parameter int         ROWS  = 8,
   parameter logic [7:0] BLANK = 8'h20
) (
   input logic                 clk,
   input logic                 rst,
   text_buffer_writer_if.slave bus
);
   localparam logic [7:0] LAST_X = 8'(COLS - 1);
   localparam logic [7:0] LAST_Y = 8'(ROWS - 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      , S_LCLEAR
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
   logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [7:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_data_q, wr_data_d;
   logic       wr_en_q, wr_en_d, ready_q, ready_d, busy_q, busy_d;

   logic       char_ready_c, accept, printable;
   logic       dec_write;
   logic [7:0] dec_data, dec_x, dec_nx, dec_ny, wrap_y;

   // A clear request masks ready in the same cycle so the source holds its byte.
   assign char_ready_c = ready_q & ~bus.clear;
   assign accept       = bus.char_valid & char_ready_c;
   assign printable    = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);
   assign wrap_y       = (cur_y_q == LAST_Y) ? 8'd0 : cur_y_q + 8'd1;

`ifdef TEXT_WRITER_LINE_CLEAR_EN
   logic row_adv;
   assign row_adv = (printable && (cur_x_q == LAST_X)) || (bus.char_in == 8'h0A);
`endif

   always_comb begin
      dec_write = 1'b0;
      dec_data  = bus.char_in;
      dec_x     = cur_x_q;
      dec_nx    = cur_x_q;
      dec_ny    = cur_y_q;
      if (printable) begin
         dec_write = 1'b1;
         if (cur_x_q == LAST_X) begin
            dec_nx = 8'd0;
            dec_ny = wrap_y;
         end else begin
            dec_nx = cur_x_q + 8'd1;
         end
      end else if (bus.char_in == 8'h0A) begin
         dec_nx = 8'd0;
         dec_ny = wrap_y;
      end else if (bus.char_in == 8'h0D) begin
         dec_nx = 8'd0;
      end else if ((bus.char_in == 8'h08) && (cur_x_q != 8'd0)) begin
         dec_write = 1'b1;
         dec_data  = BLANK;
         dec_x     = cur_x_q - 8'd1;
         dec_nx    = cur_x_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: begin
            if (!bus.clear && (clr_x_q == LAST_X) && (clr_y_q == LAST_Y)) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (bus.clear) begin
               state_d = S_CLEAR;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
            end else if (accept && row_adv) begin
               state_d = S_LCLEAR;
`endif
            end
         end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
         S_LCLEAR: begin
            if (bus.clear) begin
               state_d = S_CLEAR;
            end else if (clr_x_q == LAST_X) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_CLEAR;
      endcase
   end

   // Computes the next value of every registered output; ready rises one cycle after a sweep ends.
   always_comb begin
      clr_x_d   = clr_x_q;
      clr_y_d   = clr_y_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      wr_en_d   = 1'b0;
      wr_x_d    = wr_x_q;
      wr_y_d    = wr_y_q;
      wr_data_d = wr_data_q;
      ready_d   = 1'b0;
      busy_d    = 1'b1;
      case (state_q)
         S_CLEAR: begin
            cur_x_d = 8'd0;
            cur_y_d = 8'd0;
            if (bus.clear) begin
               clr_x_d = 8'd0;
               clr_y_d = 8'd0;
            end else begin
               wr_en_d   = 1'b1;
               wr_x_d    = clr_x_q;
               wr_y_d    = clr_y_q;
               wr_data_d = BLANK;
               if (clr_x_q == LAST_X) begin
                  clr_x_d = 8'd0;
                  clr_y_d = (clr_y_q == LAST_Y) ? 8'd0 : clr_y_q + 8'd1;
               end else begin
                  clr_x_d = clr_x_q + 8'd1;
               end
            end
         end
         S_IDLE: begin
            if (bus.clear) begin
               clr_x_d = 8'd0;
               clr_y_d = 8'd0;
            end else begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
               if (accept) begin
                  wr_en_d = dec_write;
                  if (dec_write) begin
                     wr_x_d    = dec_x;
                     wr_y_d    = cur_y_q;
                     wr_data_d = dec_data;
                  end
                  cur_x_d = dec_nx;
                  cur_y_d = dec_ny;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                  if (row_adv) begin
                     ready_d = 1'b0;
                     busy_d  = 1'b1;
                     clr_x_d = 8'd0;
                     clr_y_d = dec_ny;
                  end
`endif
               end
            end
         end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
         S_LCLEAR: begin
            if (bus.clear) begin
               clr_x_d = 8'd0;
               clr_y_d = 8'd0;
            end else begin
               wr_en_d   = 1'b1;
               wr_x_d    = clr_x_q;
               wr_y_d    = clr_y_q;
               wr_data_d = BLANK;
               clr_x_d   = (clr_x_q == LAST_X) ? 8'd0 : clr_x_q + 8'd1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_x_q   <= 8'd0;
         clr_y_q   <= 8'd0;
         cur_x_q   <= 8'd0;
         cur_y_q   <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_x_q    <= 8'd0;
         wr_y_q    <= 8'd0;
         wr_data_q <= 8'd0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         clr_x_q   <= clr_x_d;
         clr_y_q   <= clr_y_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         wr_en_q   <= wr_en_d;
         wr_x_q    <= wr_x_d;
         wr_y_q    <= wr_y_d;
         wr_data_q <= wr_data_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.char_ready = char_ready_c;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_x       = wr_x_q;
   assign bus.wr_y       = wr_y_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.cursor_x   = cur_x_q;
   assign bus.cursor_y   = cur_y_q;
   assign bus.busy       = busy_q;
endmodule
